dmem_access_unit: RTL and testbench

Sub-word data-memory access stage sitting directly downstream of the single-cycle MIPS core's data port, between the core (ALU result as address, rt value as store data, load/store decode) and a word-wide data memory with a ready handshake. Adds byte/halfword loads (sign- or zero-extended) and stores via read-modify-write. Stalls the core through a request/done handshake while the multi-cycle memory sequence runs.

---
 rtl/mips_mem_pkg.sv | 29 ++
 rtl/dmem_lane_mux.sv | 41 ++++
 rtl/dmem_access_unit.sv | 121 ++++++++++++
 tb/tb_dmem_access_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the sub-word data-memory access path: size codes,
// FSM states and lane/alignment helpers.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE,
        S_ERR
    } state_t;

    // Reserved size code 3 behaves as a full word.
    function automatic logic is_word(input logic [1:0] size);
        return (size != SZ_BYTE) && (size != SZ_HALF);
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return ((size == SZ_HALF) && lo[0]) || (is_word(size) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_lane_mux.sv
// Little-endian lane extract (load path) and lane merge (store path) for a
// 32-bit memory word. Purely combinational.
module dmem_lane_mux
    import mips_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [7:0]  bsel;
    logic [15:0] hsel;

    always_comb begin
        bsel   = word[{lane, 3'b000} +: BYTE_W];
        hsel   = word[{lane[1], 4'b0000} +: HALF_W];
        rdata  = word;
        merged = wdata;
        case (size)
            SZ_BYTE: begin
                rdata  = {{24{sext & bsel[7]}}, bsel};
                merged = word;
                merged[{lane, 3'b000} +: BYTE_W] = wdata[7:0];
            end
            SZ_HALF: begin
                rdata  = {{16{sext & hsel[15]}}, hsel};
                merged = word;
                merged[{lane[1], 4'b0000} +: HALF_W] = wdata[15:0];
            end
            default: begin
                rdata  = word;
                merged = wdata;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Sub-word load/store sequencer between the core data port and a word memory.
// Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN.
module dmem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic          sext,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          done,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-3:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ready
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic          err
`endif
);

    state_t        state, next;
    logic          we_q, sext_q;
    logic [1:0]    size_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wword_q, rdata_q;
    logic [31:0]   ext_word, merged_word;

    dmem_lane_mux u_lane_mux (
        .word   (mem_rdata),
        .lane   (addr_q[1:0]),
        .size   (size_q),
        .sext   (sext_q),
        .wdata  (wword_q),
        .rdata  (ext_word),
        .merged (merged_word)
    );

    always_comb begin
        next  = state;
        done  = 1'b0;
        rdata = 32'd0;
        busy  = (state != S_IDLE) | req;
        case (state)
            S_IDLE: begin
                if (req) begin
`ifdef DMEM_MISALIGN_TRAP_EN
                    if (misaligned(size, addr[1:0]))
                        next = S_ERR;
                    else
`endif
                    if (we && is_word(size))
                        next = S_WR;
                    else
                        next = S_RD;
                end
            end
            S_RD:   if (mem_ready) next = we_q ? S_WR : S_DONE;
            S_WR:   if (mem_ready) next = S_DONE;
            S_DONE: begin
                done  = 1'b1;
                rdata = rdata_q;
                next  = S_IDLE;
            end
            S_ERR: begin
                done = 1'b1;
                next = S_IDLE;
            end
            default: next = S_IDLE;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign err = (state == S_ERR);
`endif

    assign mem_addr  = addr_q[AW-1:2];
    assign mem_wdata = wword_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wword_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state  <= next;
            // Strobes follow next-state so they drop the cycle after mem_ready.
            mem_en <= (next == S_RD) || (next == S_WR);
            mem_we <= (next == S_WR);
            if (state == S_IDLE && req) begin
                we_q    <= we;
                size_q  <= size;
                sext_q  <= sext;
                addr_q  <= addr;
                wword_q <= wdata;
            end
            if (state == S_RD && mem_ready) begin
                if (we_q)
                    wword_q <= merged_word;
                else
                    rdata_q <= ext_word;
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit against a small behavioural word memory.
// Build with DMEM_MISALIGN_TRAP_EN defined to exercise the trap variant.
module tb_dmem_access_unit;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req, we, sext;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [31:0]   wdata, rdata, mem_wdata, mem_rdata;
    logic          done, busy, mem_en, mem_we, mem_ready;
    logic [AW-3:0] mem_addr;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic          err;
`endif

    always #5 clk = ~clk;

    dmem_access_unit #(.AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .size      (size),
        .sext      (sext),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .done      (done),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
`ifdef DMEM_MISALIGN_TRAP_EN
        ,
        .err       (err)
`endif
    );

    // Behavioural memory; preloads and stall control come from the initial block.
    logic [31:0] mem [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = 8'd0;
    logic [31:0] pre_val = 32'd0;
    int          stall_total = 0;
    int          stall_used = 0;
    logic        hold_wr = 1'b0;
    int          write_cnt = 0;

    assign mem_ready = (stall_used >= stall_total) && !(hold_wr && mem_we);
    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_val;
        if (!mem_en) stall_used <= 0;
        else if (stall_used < stall_total) stall_used <= stall_used + 1;
        if (mem_en && mem_we && mem_ready) begin
            mem[mem_addr[7:0]] <= mem_wdata;
            write_cnt <= write_cnt + 1;
        end
    end

    int          vectors = 0;
    int          miscompares = 0;
    int          lat, en_cyc, wr_cyc, wc0;
    logic        got_done, busy_acc, err_v;
    logic [31:0] rd_v, wd_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        pre_idx = idx;
        pre_val = val;
        pre_we  = 1'b1;
        @(posedge clk);
        #1 pre_we = 1'b0;
        @(negedge clk);
    endtask

    // Issue one request at a negedge; counts cycles from the accepting cycle to done.
    task automatic run_op(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = d;
        lat = 0; en_cyc = 0; wr_cyc = 0; got_done = 1'b0; rd_v = 32'd0; err_v = 1'b0; wd_v = 32'd0;
        #1 busy_acc = busy;
        while (!got_done && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (mem_en) en_cyc++;
            if (mem_en && mem_we) begin
                wr_cyc++;
                wd_v = mem_wdata;
            end
            if (done) begin
                got_done = 1'b1;
                rd_v = rdata;
`ifdef DMEM_MISALIGN_TRAP_EN
                err_v = err;
`endif
            end
        end
        req = 1'b0;
        chk("done_seen", {31'd0, got_done}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; sext = 1'b0;
        addr = '0; wdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {2'b00, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("rst_err", {31'd0, err}, 32'd0);
`endif
        reset = 1'b1;
        @(negedge clk);

        // Loads from word 0x8899AABC at 0x100
        preload(8'h40, 32'h8899AABC);
        run_op(1'b0, 2'd0, 1'b1, 32'h101, 32'd0);
        chk("lb_rdata", rd_v, 32'hFFFFFFAA);
        chk("lb_lat", lat, 32'd2);
        chk("lb_busy_accept", {31'd0, busy_acc}, 32'd1);
        chk("lb_en_cycles", en_cyc, 32'd1);
        chk("post_done_pulse", {31'd0, done}, 32'd0);
        run_op(1'b0, 2'd0, 1'b0, 32'h101, 32'd0);
        chk("lbu_rdata", rd_v, 32'h000000AA);
        run_op(1'b0, 2'd1, 1'b1, 32'h102, 32'd0);
        chk("lh_rdata", rd_v, 32'hFFFF8899);
        run_op(1'b0, 2'd1, 1'b0, 32'h102, 32'd0);
        chk("lhu_rdata", rd_v, 32'h00008899);
        run_op(1'b0, 2'd2, 1'b1, 32'h100, 32'd0);
        chk("lw_rdata", rd_v, 32'h8899AABC);

        // sb 0x5A to 0x103 on 0x11223344: RMW
        preload(8'h40, 32'h11223344);
        wc0 = write_cnt;
        run_op(1'b1, 2'd0, 1'b0, 32'h103, 32'h0000005A);
        chk("sb_lat", lat, 32'd3);
        chk("sb_wr_cycles", wr_cyc, 32'd1);
        chk("sb_en_cycles", en_cyc, 32'd2);
        chk("sb_mem_wdata", wd_v, 32'h5A223344);
        chk("sb_write_count", write_cnt - wc0, 32'd1);
        run_op(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
        chk("sb_readback", rd_v, 32'h5A223344);

        // sw with three memory wait cycles
        stall_total = 3;
        wc0 = write_cnt;
        run_op(1'b1, 2'd2, 1'b0, 32'h200, 32'hDEADBEEF);
        stall_total = 0;
        chk("sw_lat", lat, 32'd5);
        chk("sw_wr_cycles", wr_cyc, 32'd4);
        chk("sw_write_count", write_cnt - wc0, 32'd1);
        chk("sw_mem_word", mem[8'h80], 32'hDEADBEEF);

        // Reset asserted while an sh sits in WR
        preload(8'h41, 32'h01020304);
        wc0 = write_cnt;
        hold_wr = 1'b1;
        req = 1'b1; we = 1'b1; size = 2'd1; sext = 1'b0; addr = 32'h106; wdata = 32'h0000CAFE;
        @(posedge clk);
        @(negedge clk);
        chk("sh_rd_en", {30'd0, mem_en, mem_we}, 32'd2);
        @(posedge clk);
        @(negedge clk);
        chk("sh_wr_en", {30'd0, mem_en, mem_we}, 32'd3);
        reset = 1'b0;
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_en", {30'd0, mem_en, mem_we}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        hold_wr = 1'b0;
        @(negedge clk);
        chk("rst_mid_no_write", write_cnt - wc0, 32'd0);
        run_op(1'b0, 2'd2, 1'b0, 32'h104, 32'd0);
        chk("after_rst_lw", rd_v, 32'h01020304);
        chk("after_rst_lat", lat, 32'd2);

        // Misaligned word load at 0x102
        run_op(1'b0, 2'd2, 1'b0, 32'h102, 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("mis_err", {31'd0, err_v}, 32'd1);
        chk("mis_lat", lat, 32'd1);
        chk("mis_en_cycles", en_cyc, 32'd0);
        chk("mis_rdata", rd_v, 32'd0);
        chk("mis_err_after", {31'd0, err}, 32'd0);
`else
        chk("mis_rdata", rd_v, 32'h5A223344);
        chk("mis_lat", lat, 32'd2);
        run_op(1'b0, 2'd1, 1'b0, 32'h103, 32'd0);
        chk("mis_lhu_rdata", rd_v, 32'h00005A22);
`endif
        // Reserved size 3 acts as a word and ignores sext
        run_op(1'b0, 2'd3, 1'b1, 32'h104, 32'd0);
        chk("sz3_rdata", rd_v, 32'h01020304);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
